// File: rtl/vm_pkg.sv
// Shared encodings for the vending-machine controller: FSM states, coin-acceptor
// codes, coin values and change-dispenser codes.
package vm_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CREDIT = 2'b01,
    ST_VEND   = 2'b10,
    ST_CHANGE = 2'b11
  } state_t;

  localparam logic [1:0] CASH_NONE = 2'b00;
  localparam logic [1:0] CASH_5    = 2'b01;
  localparam logic [1:0] CASH_10   = 2'b10;
  localparam logic [1:0] CASH_20   = 2'b11;

  localparam logic [1:0] CHG_NONE  = 2'b00;
  localparam logic [1:0] CHG_5     = 2'b01;
  localparam logic [1:0] CHG_10    = 2'b10;

  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;
  localparam int VAL_20 = 20;

  function automatic int cash_value(input logic [1:0] code);
    case (code)
      CASH_5:  return VAL_5;
      CASH_10: return VAL_10;
      CASH_20: return VAL_20;
      default: return 0;
    endcase
  endfunction

  function automatic int chg_value(input logic [1:0] code);
    case (code)
      CHG_5:   return VAL_5;
      CHG_10:  return VAL_10;
      default: return 0;
    endcase
  endfunction
endpackage

// File: rtl/vm_change_disp.sv
// Change dispenser handshake: offers one coin at a time (10tk while credit >= 10,
// else 5tk) and reports the credit left after each accepted coin.
module vm_change_disp
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_load_credit,
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic                i_ack,
  output logic                o_valid,
  output logic [1:0]          o_coin,
  output logic                o_take,
  output logic [CREDIT_W-1:0] o_credit_nxt,
  output logic                o_done
);
  logic       r_valid;
  logic [1:0] r_coin;

  function automatic logic [1:0] pick(input logic [CREDIT_W-1:0] c);
    return (c >= CREDIT_W'(VAL_10)) ? CHG_10 : CHG_5;
  endfunction

  // Credit is always a multiple of 5, so the subtraction cannot underflow.
  assign o_take       = r_valid && i_ack;
  assign o_credit_nxt = i_credit - CREDIT_W'(chg_value(r_coin));
  assign o_done       = o_take && (o_credit_nxt == '0);
  assign o_valid      = r_valid;
  assign o_coin       = r_coin;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_coin  <= CHG_NONE;
    end else if (i_load) begin
      r_valid <= (i_load_credit != '0);
      r_coin  <= (i_load_credit != '0) ? pick(i_load_credit) : CHG_NONE;
    end else if (o_take) begin
      if (o_done) begin
        r_valid <= 1'b0;
        r_coin  <= CHG_NONE;
      end else begin
        r_coin  <= pick(o_credit_nxt);
      end
    end
  end
endmodule

// File: rtl/vm_multi_product.sv
// Multi-product vending controller: credit accumulation, selection/vend, cancel and
// inactivity refund through the change dispenser. All outputs are registered.
module vm_multi_product
  import vm_pkg::*;
#(
  parameter int                            NUM_PROD   = 4,
  parameter int                            SEL_W      = 2,
  parameter int                            CREDIT_W   = 7,
  parameter int                            MAX_CREDIT = 60,
  parameter logic [NUM_PROD*CREDIT_W-1:0]  PRICE_LIST = {7'd20, 7'd15, 7'd10, 7'd5},
  parameter int                            TIMEOUT    = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          cash_in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  input  logic                change_ack,
  output logic                purchase,
  output logic [SEL_W-1:0]    product,
  output logic                sel_deny,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          present_state
);
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_purchase, r_sel_deny, r_coin_reject;
  logic [SEL_W-1:0]    r_product;

  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_price, w_credit_nxt;
  logic w_idle_cr, w_cancel_go, w_sel_ok, w_vend_go, w_coin_go, w_tmo, w_load;
  logic w_take, w_done;

  always_comb begin
    w_price = '0;
    for (int i = 0; i < NUM_PROD; i++)
      if (sel == SEL_W'(i)) w_price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
  end

  // One extra bit so an over-ceiling sum is caught instead of wrapping.
  assign w_sum       = {1'b0, r_credit} + (CREDIT_W+1)'(cash_value(cash_in));
  assign w_idle_cr   = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
  assign w_cancel_go = w_idle_cr && cancel && (r_credit != '0);
  assign w_sel_ok    = ({1'b0, sel} < (SEL_W+1)'(NUM_PROD)) && (r_credit >= w_price);
  assign w_vend_go   = w_idle_cr && !w_cancel_go && sel_valid && w_sel_ok;
  assign w_coin_go   = w_idle_cr && !w_cancel_go && !sel_valid && coin_valid &&
                       (cash_in != CASH_NONE) && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_tmo       = (r_state == ST_CREDIT) && !w_cancel_go && !w_vend_go && !w_coin_go &&
                       (r_timer == TIMER_W'(TIMEOUT));
  assign w_load      = w_cancel_go || w_tmo || ((r_state == ST_VEND) && (r_credit != '0));

  vm_change_disp #(.CREDIT_W(CREDIT_W)) u_disp (
    .clock         (clock),
    .reset         (reset),
    .i_load        (w_load),
    .i_load_credit (r_credit),
    .i_credit      (r_credit),
    .i_ack         (change_ack && (r_state == ST_CHANGE)),
    .o_valid       (change_valid),
    .o_coin        (change_coin),
    .o_take        (w_take),
    .o_credit_nxt  (w_credit_nxt),
    .o_done        (w_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_credit      <= '0;
      r_timer       <= '0;
      r_purchase    <= 1'b0;
      r_product     <= '0;
      r_sel_deny    <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_purchase    <= w_vend_go;
      r_product     <= w_vend_go ? sel : '0;
      r_sel_deny    <= w_idle_cr && !w_cancel_go && sel_valid && !w_sel_ok;
      r_coin_reject <= coin_valid && !w_coin_go;
      case (r_state)
        ST_IDLE, ST_CREDIT: begin
          if (w_cancel_go || w_tmo) begin
            r_state <= ST_CHANGE;
            r_timer <= '0;
          end else if (w_vend_go) begin
            r_state  <= ST_VEND;
            r_credit <= r_credit - w_price;
            r_timer  <= '0;
          end else if (w_coin_go) begin
            r_state  <= ST_CREDIT;
            r_credit <= w_sum[CREDIT_W-1:0];
            r_timer  <= '0;
          end else if ((r_state == ST_CREDIT) && (r_timer != TIMER_W'(TIMEOUT))) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_VEND: r_state <= (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        default: begin
          if (w_take) r_credit <= w_credit_nxt;
          if (w_done) r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign purchase      = r_purchase;
  assign product       = r_product;
  assign sel_deny      = r_sel_deny;
  assign coin_reject   = r_coin_reject;
  assign credit        = r_credit;
  assign present_state = r_state;
endmodule

// File: tb/tb_vm_multi_product.sv
// Bench for vm_multi_product: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the vending rules.
`timescale 1ns/1ps
module tb_vm_multi_product;
  localparam int TIMEOUT = 255;
  localparam int MAXC    = 60;
  localparam int M_IDLE = 0, M_CREDIT = 1, M_VEND = 2, M_CHANGE = 3;

  logic       clock = 1'b0, reset = 1'b0;
  logic       coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, change_ack = 1'b0;
  logic [1:0] cash_in = 2'b00, sel = 2'b00;
  logic       purchase, sel_deny, coin_reject, change_valid;
  logic [1:0] product, change_coin, present_state;
  logic [6:0] credit;

  int prices[4] = '{5, 10, 15, 20};
  int m_st, m_credit, m_timer, m_purchase, m_product, m_deny, m_rej, m_cv, m_cc;
  int n_vec = 0, n_cmp = 0, n_err = 0;

  vm_multi_product dut (
    .clock(clock), .reset(reset), .coin_valid(coin_valid), .cash_in(cash_in),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .change_ack(change_ack),
    .purchase(purchase), .product(product), .sel_deny(sel_deny),
    .coin_reject(coin_reject), .change_valid(change_valid), .change_coin(change_coin),
    .credit(credit), .present_state(present_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_credit = 0; m_timer = 0; m_purchase = 0; m_product = 0;
    m_deny = 0; m_rej = 0; m_cv = 0; m_cc = 0;
  endtask

  task automatic offer();
    m_cv = 1;
    m_cc = (m_credit >= 10) ? 2 : 1;
  endtask

  task automatic idle_tick();
    if (m_st == M_CREDIT) begin
      if (m_timer >= TIMEOUT) begin m_st = M_CHANGE; m_timer = 0; offer(); end
      else m_timer++;
    end
  endtask

  task automatic model(input bit cv, input bit [1:0] cash, input bit sv, input bit [1:0] s,
                       input bit can, input bit ack);
    int val;
    bit taken;
    val = (cash == 2'd1) ? 5 : (cash == 2'd2) ? 10 : (cash == 2'd3) ? 20 : 0;
    m_purchase = 0; m_product = 0; m_deny = 0; taken = 0;
    if (m_st == M_IDLE || m_st == M_CREDIT) begin
      if (can && m_credit > 0) begin
        m_st = M_CHANGE; m_timer = 0; offer();
      end else if (sv) begin
        if (m_credit >= prices[s]) begin
          m_credit -= prices[s]; m_purchase = 1; m_product = s; m_st = M_VEND; m_timer = 0;
        end else begin
          m_deny = 1; idle_tick();
        end
      end else if (cv && val > 0 && m_credit + val <= MAXC) begin
        m_credit += val; m_st = M_CREDIT; m_timer = 0; taken = 1;
      end else idle_tick();
    end else if (m_st == M_VEND) begin
      if (m_credit > 0) begin m_st = M_CHANGE; offer(); end
      else m_st = M_IDLE;
    end else if (ack) begin
      m_credit -= (m_cc == 2) ? 10 : 5;
      if (m_credit == 0) begin m_cv = 0; m_cc = 0; m_st = M_IDLE; end
      else m_cc = (m_credit >= 10) ? 2 : 1;
    end
    m_rej = (cv && !taken) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("state",        32'(present_state), m_st);
    chk("credit",       32'(credit),        m_credit);
    chk("purchase",     32'(purchase),      m_purchase);
    chk("product",      32'(product),       m_product);
    chk("sel_deny",     32'(sel_deny),      m_deny);
    chk("coin_reject",  32'(coin_reject),   m_rej);
    chk("change_valid", 32'(change_valid),  m_cv);
    chk("change_coin",  32'(change_coin),   m_cc);
  endtask

  task automatic step(input bit cv, input bit [1:0] cash, input bit sv, input bit [1:0] s,
                      input bit can, input bit ack);
    coin_valid = cv; cash_in = cash; sel_valid = sv; sel = s; cancel = can; change_ack = ack;
    @(posedge clock);
    model(cv, cash, sv, s, can, ack);
    #1;
    n_vec++;
    check_all();
    coin_valid = 0; cash_in = 0; sel_valid = 0; sel = 0; cancel = 0; change_ack = 0;
  endtask

  initial begin
    int cnt;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;
    @(posedge clock); #1;

    // 1: async reset in the middle of CREDIT (credit 15)
    step(1, 2'd2, 0, 0, 0, 0);
    step(1, 2'd1, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clock); #1;
    reset = 1'b1;

    // 2: 5+5, buy product 1 (10), no change
    step(1, 2'd1, 0, 0, 0, 0);
    step(1, 2'd1, 0, 0, 0, 0);
    step(0, 0, 1, 2'd1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // 3: 20, buy product 2 (15), one 5tk change coin
    step(1, 2'd3, 0, 0, 0, 0);
    step(0, 0, 1, 2'd2, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // 4: fill to 60, over-ceiling coin rejected, cancel refunds six 10tk coins
    repeat (3) step(1, 2'd3, 0, 0, 0, 0);
    step(1, 2'd1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (6) begin
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
    end

    // 5: deny product 3, then inactivity timeout refunds the 5tk
    step(1, 2'd1, 0, 0, 0, 0);
    step(0, 0, 1, 2'd3, 0, 0);
    cnt = 0;
    while (present_state != 2'd3 && cnt < 400) begin
      step(0, 0, 0, 0, 0, 0);
      cnt++;
    end
    chk("timeout_cycles", cnt, 255);
    step(0, 0, 0, 0, 0, 1);

    // 6: coin+sel+cancel in one cycle with credit 10, stalled ack
    step(1, 2'd2, 0, 0, 0, 0);
    step(1, 2'd2, 1, 2'd1, 1, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // random traffic
    repeat (2000) begin
      step($urandom_range(0, 99) < 30, 2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 15, 2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
